uart_rx_fifo: RTL

//  Serial receiver between the board Rx pin and the d16 core's I/O bus.
//  - Oversamples Rx 16x, deserialises 8N1 frames and buffers the bytes in a FIFO.
//  - The core drains the FIFO through a valid/ready handshake.
//  - Sticky error flags report framing and overrun faults to the core's status register.

---
 rtl/uart_rx_fifo_pkg.sv | 21 ++
 rtl/uart_rx_fifo_fifo.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling ratio and
// the baud divider rounding helper, also used by the transmitter.
package uart_rx_fifo_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // round(clk_hz / (baud * OVERSAMPLE))
  function automatic int unsigned div_round(input int unsigned clk_hz,
                                            input int unsigned baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// Show-ahead synchronous FIFO with a separate occupancy counter; a push
// into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_do;
  logic             rd_do;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign rd_do = rd_en & ~empty;
  assign wr_do = wr_en & (~full | rd_do);

  // Head entry is forced to zero while empty so the output is defined from reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + 1'b1;
      if (rd_do) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_do, rd_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling 8N1 UART receiver feeding a show-ahead byte FIFO,
// with sticky framing and overrun flags for the core's status register.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   fifo_count,
  output logic          frame_err,
  output logic          overrun,
  input  logic          err_clr
);

  localparam int unsigned DIV      = div_round(CLK_HZ, BAUD);
  localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic            rx_meta, rx_s, rx_q;
  logic            fall;
  logic [DW-1:0]   div_cnt;
  logic            tick, div_clr;
  rx_state_t       state, state_n;
  logic [3:0]      st, st_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            push, frame_set, ovr_set;
  logic            fifo_full, fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign fall = rx_q & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div_cnt <= '0;
    else if (div_clr || tick) div_cnt <= '0;
    else                     div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      st      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      st      <= st_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    st_n      = st;
    bit_n     = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    div_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          st_n    = '0;
          div_clr = 1'b1;
        end
      end
      // Start is validated mid-bit but DATA begins at the end of the start
      // bit, so DATA's st==7 lands mid-bit for every data bit.
      START: begin
        if (tick) begin
          st_n = st + 4'd1;
          if (st == 4'd7 && rx_s) begin
            state_n = IDLE;
          end else if (st == 4'd15) begin
            state_n = DATA;
            st_n    = '0;
            bit_n   = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          st_n = st + 4'd1;
          if (st == 4'd7) shreg_n = {rx_s, shreg[7:1]};
          if (st == 4'd15) begin
            if (bit_idx == 3'd7) state_n = STOP;
            else                 bit_n   = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          st_n = st + 4'd1;
          if (st == 4'd7) begin
            if (rx_s) begin
              push    = 1'b1;
              state_n = IDLE;
            end else begin
              frame_set = 1'b1;
              state_n   = BREAK;
            end
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (shreg),
    .rd_en   (rd_ready),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_valid = ~fifo_empty;
  assign ovr_set  = push & fifo_full & ~rd_ready;

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set | (frame_err & ~err_clr);
      overrun   <= ovr_set   | (overrun   & ~err_clr);
    end
  end

endmodule
